fifo_uart_tx: RTL and testbench

Read-side consumer for the team's 8-bit synchronous FIFO. Pops bytes from the FIFO read port one at a time and serializes each as an asynchronous UART frame: start bit, data LSB first, optional even parity, stop bit(s). Sits between the FIFO output and the board TX pin. Lets upstream logic stream bytes off-chip through the FIFO's write port.

---
 rtl/fifo_uart_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO read-side consumer that serializes bytes as UART frames
module fifo_uart_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done,
   output logic [15:0]       bytes_sent
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PARITY, STOP} state_t;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              par, par_n;
   logic              tx_n, done_n;
   logic [15:0]       bytes_n;
   logic              bit_end;

   assign bit_end = (cnt == CNT_LAST);
   assign tx_busy = (state != IDLE);

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      idx_n      = idx;
      shreg_n    = shreg;
      par_n      = par;
      done_n     = 1'b0;
      bytes_n    = bytes_sent;
      fifo_rd_en = 1'b0;
      case (state)
         IDLE: begin
            // Gated by rst so nothing is popped while reset is held
            if (enable && !fifo_empty) begin
               fifo_rd_en = rst;
               state_n    = FETCH;
            end
         end
         FETCH: begin
            shreg_n = fifo_dout;
            par_n   = ^fifo_dout;
            cnt_n   = '0;
            idx_n   = '0;
            state_n = START;
         end
         START: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = '0;
               if (idx == DATA_LAST) begin
                  idx_n   = '0;
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  idx_n   = idx + 1'b1;
                  shreg_n = shreg >> 1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            // idx counts stop bits here so the baud counter keeps its 0..CLKS_PER_BIT-1 range
            if (bit_end) begin
               cnt_n = '0;
               if (idx == STOP_LAST) begin
                  idx_n   = '0;
                  state_n = IDLE;
                  done_n  = 1'b1;
                  bytes_n = bytes_sent + 16'd1;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         PARITY:  tx_n = par_n;
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         idx        <= '0;
         shreg      <= '0;
         par        <= 1'b0;
         tx         <= 1'b1;
         tx_done    <= 1'b0;
         bytes_sent <= 16'd0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         shreg      <= shreg_n;
         par        <= par_n;
         tx         <= tx_n;
         tx_done    <= done_n;
         bytes_sent <= bytes_n;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx (8N1 and 8E1 instances, CLKS_PER_BIT=4)
module tb_fifo_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable0 = 1'b0, enable1 = 1'b0;
   logic [7:0]  mem0 [256];
   logic [7:0]  mem1 [256];
   int          wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
   logic [7:0]  dout0 = 8'h00, dout1 = 8'h00;
   logic        empty0, empty1;
   logic        rd_en0, tx0, busy0, done0;
   logic        rd_en1, tx1, busy1, done1;
   logic [15:0] bytes0, bytes1;
   int          total = 0, bad = 0;
   int          cyc = 0;
   int          rdc0 = 0, rdc1 = 0, viol = 0, donec0 = 0, donec1 = 0;

   assign empty0 = (wr0 == rd0);
   assign empty1 = (wr1 == rd1);

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .rst(rst), .enable(enable0), .fifo_empty(empty0), .fifo_dout(dout0),
      .fifo_rd_en(rd_en0), .tx(tx0), .tx_busy(busy0), .tx_done(done0), .bytes_sent(bytes0));

   fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(empty1), .fifo_dout(dout1),
      .fifo_rd_en(rd_en1), .tx(tx1), .tx_busy(busy1), .tx_done(done1), .bytes_sent(bytes1));

   // FIFO models: read data appears the cycle after the pop
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en0 && rd0 < wr0) begin
         dout0 <= mem0[rd0];
         rd0   <= rd0 + 1;
      end
      if (rd_en1 && rd1 < wr1) begin
         dout1 <= mem1[rd1];
         rd1   <= rd1 + 1;
      end
   end

   always @(negedge clk) begin
      if (rd_en0) rdc0 <= rdc0 + 1;
      if (rd_en1) rdc1 <= rdc1 + 1;
      if ((rd_en0 && empty0) || (rd_en1 && empty1)) viol <= viol + 1;
      if (done0) donec0 <= donec0 + 1;
      if (done1) donec1 <= donec1 + 1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   function automatic logic txs(input int sel);
      return (sel == 0) ? tx0 : tx1;
   endfunction

   task automatic push(input int sel, input logic [7:0] b);
      if (sel == 0) begin
         mem0[wr0] = b;
         wr0 = wr0 + 1;
      end else begin
         mem1[wr1] = b;
         wr1 = wr1 + 1;
      end
   endtask

   task automatic do_reset();
      enable0 = 1'b0;
      enable1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_fall(input int sel, output int t0);
      int n;
      n = 0;
      t0 = 0;
      @(negedge clk);
      while (txs(sel) !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         total++; bad++;
         $display("FAIL start_timeout sel=%0d got no falling edge, required one", sel);
      end
      t0 = cyc;
   endtask

   task automatic recv(input int sel, input bit drop, output logic [7:0] d, output logic p,
                       output logic sb, output logic st, output int t0);
      d = 8'h00;
      p = 1'b0;
      wait_fall(sel, t0);
      @(negedge clk);
      sb = txs(sel);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         d[i] = txs(sel);
         if (drop && i == 1) enable0 = 1'b0;
      end
      if (sel == 1) begin
         repeat (4) @(negedge clk);
         p = txs(sel);
      end
      repeat (4) @(negedge clk);
      st = txs(sel);
   endtask

   task automatic wait_done(input int sel, output int t);
      int n;
      n = 0;
      while (((sel == 0) ? done0 : done1) !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         total++; bad++;
         $display("FAIL done_timeout sel=%0d got no tx_done, required one", sel);
      end
      t = cyc;
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || bytes0 !== 16'd0 || done0 !== 1'b0) begin
         bad++;
         $display("FAIL reset_idle got tx=%b busy=%b done=%b bytes=%0d required 1 0 0 0", tx0, busy0, done0, bytes0);
      end
      push(0, 8'h11);
      enable0 = 1'b1;
      n = 0;
      while (busy0 !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_start got tx=%b busy=%b required 0 1", tx0, busy0);
      end
      #1 rst = 1'b0;
      #1;
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rd_en0 !== 1'b0 || bytes0 !== 16'd0) begin
         bad++;
         $display("FAIL reset_async got tx=%b busy=%b done=%b rd_en=%b bytes=%0d required 1 0 0 0 0",
                  tx0, busy0, done0, rd_en0, bytes0);
      end
      repeat (2) @(negedge clk);
      enable0 = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [7:0] d;
      logic p, sb, st;
      int t0, t, b_rd, b_dn;
      do_reset();
      b_rd = rdc0;
      b_dn = donec0;
      push(0, 8'hA5);
      enable0 = 1'b1;
      recv(0, 1'b0, d, p, sb, st, t0);
      total++;
      if (sb !== 1'b0 || d !== 8'hA5 || st !== 1'b1) begin
         bad++;
         $display("FAIL single_frame got start=%b data=%h stop=%b required 0 a5 1", sb, d, st);
      end
      wait_done(0, t);
      total++;
      if (t - t0 !== 40) begin
         bad++;
         $display("FAIL single_length got %0d required 40", t - t0);
      end
      repeat (3) @(negedge clk);
      total++;
      if (rdc0 - b_rd !== 1 || donec0 - b_dn !== 1 || bytes0 !== 16'd1 || empty0 !== 1'b1) begin
         bad++;
         $display("FAIL single_counts got rd=%0d done=%0d bytes=%0d empty=%b required 1 1 1 1",
                  rdc0 - b_rd, donec0 - b_dn, bytes0, empty0);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      logic p, sb, st;
      int t0, prev, t, b_rd, b_v;
      do_reset();
      for (int i = 0; i < 64; i++) push(0, 8'(i));
      b_rd = rdc0;
      b_v = viol;
      prev = 0;
      enable0 = 1'b1;
      for (int i = 0; i < 64; i++) begin
         recv(0, 1'b0, d, p, sb, st, t0);
         total++;
         if (d !== 8'(i) || sb !== 1'b0 || st !== 1'b1) begin
            bad++;
            $display("FAIL stream_byte%0d got data=%h start=%b stop=%b required %h 0 1", i, d, sb, st, 8'(i));
         end
         if (i > 0) begin
            total++;
            if (t0 - prev !== 42) begin
               bad++;
               $display("FAIL stream_gap%0d got %0d required 42", i, t0 - prev);
            end
         end
         prev = t0;
      end
      wait_done(0, t);
      repeat (3) @(negedge clk);
      total++;
      if (rdc0 - b_rd !== 64 || viol - b_v !== 0 || bytes0 !== 16'd64 || empty0 !== 1'b1) begin
         bad++;
         $display("FAIL stream_counts got rd=%0d viol=%0d bytes=%0d empty=%b required 64 0 64 1",
                  rdc0 - b_rd, viol - b_v, bytes0, empty0);
      end
   endtask

   task automatic test_parity();
      logic [7:0] d;
      logic p, sb, st;
      int t0, t;
      do_reset();
      push(1, 8'h07);
      enable1 = 1'b1;
      recv(1, 1'b0, d, p, sb, st, t0);
      total++;
      if (d !== 8'h07 || p !== 1'b1 || sb !== 1'b0 || st !== 1'b1) begin
         bad++;
         $display("FAIL parity_07 got data=%h par=%b start=%b stop=%b required 07 1 0 1", d, p, sb, st);
      end
      wait_done(1, t);
      total++;
      if (t - t0 !== 44) begin
         bad++;
         $display("FAIL parity_length got %0d required 44", t - t0);
      end
      push(1, 8'h03);
      recv(1, 1'b0, d, p, sb, st, t0);
      total++;
      if (d !== 8'h03 || p !== 1'b0 || st !== 1'b1) begin
         bad++;
         $display("FAIL parity_03 got data=%h par=%b stop=%b required 03 0 1", d, p, st);
      end
      wait_done(1, t);
      total++;
      if (bytes1 !== 16'd2) begin
         bad++;
         $display("FAIL parity_bytes got %0d required 2", bytes1);
      end
      enable1 = 1'b0;
   endtask

   task automatic test_enable_drop();
      logic [7:0] d;
      logic p, sb, st;
      int t0, t, b_rd, b_dn;
      do_reset();
      push(0, 8'h3C);
      push(0, 8'hC3);
      b_rd = rdc0;
      b_dn = donec0;
      enable0 = 1'b1;
      recv(0, 1'b1, d, p, sb, st, t0);
      total++;
      if (d !== 8'h3C || st !== 1'b1) begin
         bad++;
         $display("FAIL drop_first got data=%h stop=%b required 3c 1", d, st);
      end
      wait_done(0, t);
      repeat (20) @(negedge clk);
      total++;
      if (donec0 - b_dn !== 1 || rdc0 - b_rd !== 1 || wr0 - rd0 !== 1 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL drop_hold got done=%0d rd=%0d left=%0d busy=%b required 1 1 1 0",
                  donec0 - b_dn, rdc0 - b_rd, wr0 - rd0, busy0);
      end
      enable0 = 1'b1;
      recv(0, 1'b0, d, p, sb, st, t0);
      total++;
      if (d !== 8'hC3 || sb !== 1'b0 || st !== 1'b1) begin
         bad++;
         $display("FAIL drop_second got data=%h start=%b stop=%b required c3 0 1", d, sb, st);
      end
      wait_done(0, t);
      total++;
      if (bytes0 !== 16'd2) begin
         bad++;
         $display("FAIL drop_bytes got %0d required 2", bytes0);
      end
      enable0 = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] d;
      logic p, sb, st;
      int t0, t;
      do_reset();
      push(0, 8'h55);
      push(0, 8'hAA);
      enable0 = 1'b1;
      wait_fall(0, t0);
      repeat (17) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      total++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL midreset_async got tx=%b busy=%b required 1 0", tx0, busy0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      recv(0, 1'b0, d, p, sb, st, t0);
      total++;
      if (d !== 8'hAA || sb !== 1'b0 || st !== 1'b1) begin
         bad++;
         $display("FAIL midreset_frame got data=%h start=%b stop=%b required aa 0 1", d, sb, st);
      end
      wait_done(0, t);
      total++;
      if (bytes0 !== 16'd1 || empty0 !== 1'b1) begin
         bad++;
         $display("FAIL midreset_bytes got bytes=%0d empty=%b required 1 1", bytes0, empty0);
      end
      enable0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_enable_drop();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
